irda_nec_rx: RTL and testbench



---
 rtl/irda_nec_rx.sv | 141 ++++++++++++++
 tb/tb_irda_nec_rx.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/irda_nec_rx.sv
// irda_nec_rx: NEC infrared frame receiver producing the command byte plus repeat and error pulses
module irda_nec_rx #(
    parameter int CLK_DIV       = 500,
    parameter int TIMEOUT_TICKS = 1200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ir_in,
    output logic [9:0] data_out,
    output logic       data_valid,
    output logic       repeat_pulse,
    output logic       err
);
    localparam int PW = $clog2(CLK_DIV);
    typedef enum logic [2:0] {
        IDLE, LEAD_MARK, LEAD_SPACE, REP_MARK, BIT_MARK, BIT_SPACE, STOP_MARK, CHECK
    } state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] pre_q;
    logic [2:0]    sync_q;
    logic [10:0]   wid_q;
    logic [5:0]    cnt_q, cnt_d;
    logic [31:0]   sr_q, sr_d;
    logic [9:0]    data_q, data_d;
    logic          dv_q, dv_d, rep_q, rep_d, err_q, err_d;
    logic          tick, fall, rise, timeout, frame_ok;
    logic          lead_ok, lsp_ok, rsp_ok, mark_ok, zero_ok, one_ok;

    function automatic logic win(input logic [10:0] w, input logic [10:0] lo, input logic [10:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

    assign tick     = pre_q == PW'(CLK_DIV - 1);
    assign fall     = sync_q[2] & ~sync_q[1];
    assign rise     = ~sync_q[2] & sync_q[1];
    assign timeout  = (state_q != IDLE) && (state_q != CHECK) && (wid_q > 11'(TIMEOUT_TICKS));
    assign lead_ok  = win(wid_q, 11'd800, 11'd1000);
    assign lsp_ok   = win(wid_q, 11'd400, 11'd500);
    assign rsp_ok   = win(wid_q, 11'd200, 11'd250);
    assign mark_ok  = win(wid_q, 11'd40, 11'd70);
    assign zero_ok  = win(wid_q, 11'd40, 11'd70);
    assign one_ok   = win(wid_q, 11'd140, 11'd200);
    assign frame_ok = (sr_q[7:0] == ~sr_q[15:8]) && (sr_q[23:16] == ~sr_q[31:24]);

    assign data_out     = data_q;
    assign data_valid   = dv_q;
    assign repeat_pulse = rep_q;
    assign err          = err_q;

    // Sample-tick prescaler, input synchroniser with edge history, saturating pulse-width counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q  <= '0;
            sync_q <= 3'b111;
            wid_q  <= '0;
        end else begin
            pre_q  <= tick ? '0 : pre_q + 1'b1;
            sync_q <= {sync_q[1:0], ir_in};
            wid_q  <= (fall | rise) ? '0 : (tick && wid_q != 11'h7FF) ? wid_q + 11'd1 : wid_q;
        end
    end

    // Frame state, shift register and registered output pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sr_q    <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            rep_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sr_q    <= sr_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            rep_q   <= rep_d;
            err_q   <= err_d;
        end
    end

    // Width is judged at each edge against the window expected in the current phase of the frame
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sr_d    = sr_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        rep_d   = 1'b0;
        err_d   = 1'b0;
        if (timeout) begin
            err_d   = 1'b1;
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: if (fall) state_d = LEAD_MARK;
                LEAD_MARK: if (rise) begin
                    state_d = lead_ok ? LEAD_SPACE : IDLE;
                    err_d   = !lead_ok;
                end
                LEAD_SPACE: if (fall) begin
                    state_d = lsp_ok ? BIT_MARK : rsp_ok ? REP_MARK : IDLE;
                    err_d   = !(lsp_ok || rsp_ok);
                    cnt_d   = '0;
                end
                REP_MARK: if (rise) begin
                    state_d = IDLE;
                    rep_d   = mark_ok;
                    err_d   = !mark_ok;
                end
                BIT_MARK: if (rise) begin
                    state_d = mark_ok ? BIT_SPACE : IDLE;
                    err_d   = !mark_ok;
                end
                BIT_SPACE: if (fall) begin
                    if (zero_ok || one_ok) begin
                        sr_d    = {one_ok, sr_q[31:1]};
                        cnt_d   = cnt_q + 6'd1;
                        state_d = (cnt_q == 6'd31) ? STOP_MARK : BIT_MARK;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end
                STOP_MARK: if (rise) begin
                    state_d = mark_ok ? CHECK : IDLE;
                    err_d   = !mark_ok;
                end
                CHECK: begin
                    state_d = IDLE;
                    dv_d    = frame_ok;
                    err_d   = !frame_ok;
                    if (frame_ok) data_d = {2'b00, sr_q[23:16]};
                end
                default: state_d = IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_irda_nec_rx.sv
// tb_irda_nec_rx: randomized NEC frame stimulus checked against a frame-level expectation model
module tb_irda_nec_rx;
    localparam int DIV = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ir_in = 1'b1;
    logic [9:0] data_out;
    logic       data_valid, repeat_pulse, err;
    logic [9:0] exp_data = 10'h000;
    int         cyc, n_dv, n_rep, n_err, n_ovl, t_dv, t_rise, n_vec, n_bad;

    irda_nec_rx #(.CLK_DIV(DIV), .TIMEOUT_TICKS(1200)) dut (
        .clk(clk), .rst(rst), .ir_in(ir_in), .data_out(data_out),
        .data_valid(data_valid), .repeat_pulse(repeat_pulse), .err(err)
    );

    always #5 clk = ~clk;

    // cycle count and pulse monitor
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (data_valid) begin
            n_dv <= n_dv + 1;
            t_dv <= cyc;
        end
        if (repeat_pulse) n_rep <= n_rep + 1;
        if (err) n_err <= n_err + 1;
        n_ovl <= n_ovl + int'((data_valid & repeat_pulse) | (data_valid & err) | (repeat_pulse & err));
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic hold(input logic lvl, input int ticks);
        ir_in = lvl;
        repeat (ticks * DIV) @(negedge clk);
    endtask

    task automatic send_bits(input logic [31:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b0, $urandom_range(42, 46));
            hold(1'b1, w[i] ? $urandom_range(142, 146) : $urandom_range(42, 46));
        end
    endtask

    task automatic frame(input string tag, input logic [7:0] a, input logic [7:0] an,
                         input logic [7:0] c, input logic [7:0] cn);
        int s_dv = n_dv;
        int s_err = n_err;
        int s_rep = n_rep;
        logic ok;
        ok = (an == ~a) && (cn == ~c);
        hold(1'b1, 20);
        hold(1'b0, $urandom_range(803, 815));
        hold(1'b1, $urandom_range(403, 410));
        send_bits({cn, c, an, a}, 32);
        hold(1'b0, $urandom_range(42, 46));
        ir_in  = 1'b1;
        t_rise = cyc;
        hold(1'b1, 10);
        if (ok) exp_data = {2'b00, c};
        check({tag, " dv"}, n_dv - s_dv, int'(ok));
        check({tag, " err"}, n_err - s_err, int'(!ok));
        check({tag, " rep"}, n_rep - s_rep, 0);
        check({tag, " data"}, int'(data_out), int'(exp_data));
        if (ok) check({tag, " latency"}, t_dv - t_rise, 4);
    endtask

    task automatic rep_code(input string tag, input int mark);
        int s_dv = n_dv;
        int s_err = n_err;
        int s_rep = n_rep;
        logic good;
        good = (mark >= 42) && (mark <= 68);
        hold(1'b1, 20);
        hold(1'b0, $urandom_range(803, 815));
        hold(1'b1, $urandom_range(203, 247));
        hold(1'b0, mark);
        hold(1'b1, 20);
        check({tag, " rep"}, n_rep - s_rep, int'(good));
        check({tag, " err"}, n_err - s_err, int'(!good));
        check({tag, " dv"}, n_dv - s_dv, 0);
        check({tag, " data"}, int'(data_out), int'(exp_data));
    endtask

    initial begin
        logic [7:0] a;
        int s_dv, s_err, s_rep;
        repeat (3) @(negedge clk);
        check("reset data", int'(data_out), 0);
        check("reset dv", int'(data_valid), 0);
        check("reset rep", int'(repeat_pulse), 0);
        check("reset err", int'(err), 0);
        rst = 1'b0;
        s_dv = n_dv; s_err = n_err; s_rep = n_rep;
        hold(1'b1, 2000);
        check("idle data", int'(data_out), 0);
        check("idle pulses", (n_dv - s_dv) + (n_err - s_err) + (n_rep - s_rep), 0);

        frame("f45", 8'h00, 8'hFF, 8'h45, 8'hBA);

        s_dv = n_dv; s_err = n_err;
        hold(1'b0, 500);
        hold(1'b1, 450);
        check("short leader err", n_err - s_err, 1);
        check("short leader dv", n_dv - s_dv, 0);

        a = 8'($urandom);
        frame("f07", a, ~a, 8'h07, 8'hF8);
        rep_code("repeat", $urandom_range(42, 68));
        rep_code("bad repeat", $urandom_range(85, 100));

        a = 8'($urandom);
        frame("bad cmpl", a, ~a, 8'h45, 8'hBB);

        s_dv = n_dv; s_err = n_err;
        hold(1'b0, $urandom_range(803, 815));
        hold(1'b1, $urandom_range(403, 410));
        hold(1'b0, 1500);
        hold(1'b1, 50);
        check("timeout err", n_err - s_err, 1);
        check("timeout dv", n_dv - s_dv, 0);
        check("timeout data", int'(data_out), int'(exp_data));

        s_dv = n_dv; s_err = n_err;
        a = 8'($urandom);
        hold(1'b0, $urandom_range(803, 815));
        hold(1'b1, $urandom_range(403, 410));
        send_bits({8'hAA, 8'h55, ~a, a}, 10);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("mid rst data", int'(data_out), 0);
        rst = 1'b0;
        exp_data = 10'h000;
        hold(1'b1, 20);
        check("mid rst err", n_err - s_err, 0);
        check("mid rst dv", n_dv - s_dv, 0);

        a = 8'($urandom);
        frame("f0c", a, ~a, 8'h0C, 8'hF3);
        check("pulse overlap", n_ovl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
